// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt claim controller.
// Optional rotating priority is selected with IRQ_ROUND_ROBIN_EN.
package irq_pkg;

  localparam int IRQ_NUM_SRC = 9;
  localparam int IRQ_ID_W    = 4;

  localparam logic [IRQ_ID_W-1:0] IRQ_ID_NONE = '0;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } irq_state_e;

endpackage

// File: rtl/irq_prio_encoder.sv
// Masked priority encoder with a rotating start point.
// start_i=k begins the search at source k+1, wrapping past NUM_SRC.
module irq_prio_encoder
  import irq_pkg::*;
#(
  parameter int NUM_SRC  = IRQ_NUM_SRC,
  parameter int ID_WIDTH = IRQ_ID_W
) (
  input  logic [NUM_SRC-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] start_i,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                valid_o
);

  // first requesting source at or after the start index wins
  always_comb begin
    int base;
    int idx;
    logic [NUM_SRC-1:0] hit;
    id_o    = '0;
    valid_o = 1'b0;
    base    = int'(start_i);
    if (base >= NUM_SRC) base = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = base + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      hit = req_i >> idx;
      if (!valid_o && hit[0]) begin
        valid_o = 1'b1;
        id_o    = ID_WIDTH'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/irq_claim_controller.sv
// Edge-latching interrupt merger with ack/claim and end-of-service.
// Define IRQ_ROUND_ROBIN_EN for rotating priority.
module irq_claim_controller
  import irq_pkg::*;
#(
  parameter int                 NUM_SRC     = IRQ_NUM_SRC,
  parameter logic [NUM_SRC-1:0] INVERT_MASK = '0,
  parameter int                 ID_WIDTH    = IRQ_ID_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_SRC-1:0]  irq_src,
  input  logic [NUM_SRC-1:0]  enable_mask,
  output logic                irq_out,
  input  logic                irq_ack,
  output logic [ID_WIDTH-1:0] irq_id,
  input  logic                irq_done,
  output logic [NUM_SRC-1:0]  pending
);

  irq_state_e state_q, state_d;

  logic [NUM_SRC-1:0]  lvl;
  logic [NUM_SRC-1:0]  prev_q;
  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  pend_q, pend_d;
  logic [NUM_SRC-1:0]  live;
  logic [NUM_SRC-1:0]  clr;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ID_WIDTH-1:0] start;
  logic [ID_WIDTH-1:0] win_id;
  logic                win_vld;
  logic                claim;

  assign lvl  = irq_src ^ INVERT_MASK;
  assign rise = lvl & ~prev_q;
  assign live = pend_q & enable_mask;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] last_q;

  assign start = last_q;

  // remember the last claimed ID to rotate the search origin
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_q <= ID_WIDTH'(IRQ_ID_NONE);
    end else if (claim) begin
      last_q <= win_id;
    end
  end
`else
  assign start = ID_WIDTH'(IRQ_ID_NONE);
`endif

  irq_prio_encoder #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_enc (
    .req_i   (live),
    .start_i (start),
    .id_o    (win_id),
    .valid_o (win_vld)
  );

  // next state, claim decode and pending update
  always_comb begin
    state_d = state_q;
    claim   = 1'b0;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      IRQ_IDLE: begin
        if (|live) state_d = IRQ_REQ;
      end
      IRQ_REQ: begin
        if (!win_vld) begin
          state_d = IRQ_IDLE;
        end else if (irq_ack) begin
          state_d = IRQ_SERVICE;
          claim   = 1'b1;
          id_d    = win_id;
          clr     = NUM_SRC'(1) << (win_id - 1'b1);
        end
      end
      IRQ_SERVICE: begin
        if (irq_done) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
    // a fresh edge beats the claim clear on the same bit
    pend_d = (pend_q & ~clr) | rise;
  end

  // state, edge history, pending bits and claimed ID
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IRQ_IDLE;
      prev_q  <= '1;
      pend_q  <= '0;
      id_q    <= ID_WIDTH'(IRQ_ID_NONE);
    end else begin
      state_q <= state_d;
      prev_q  <= lvl;
      pend_q  <= pend_d;
      id_q    <= id_d;
    end
  end

  assign irq_out = (state_q == IRQ_REQ);
  assign irq_id  = id_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_irq_claim_controller.sv
// Directed self-checking bench for irq_claim_controller.
// Source 1 is configured active-low; its idle line level is 1.
module tb_irq_claim_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [8:0] irq_src;
  logic [8:0] enable_mask;
  logic       irq_out;
  logic       irq_ack;
  logic [3:0] irq_id;
  logic       irq_done;
  logic [8:0] pending;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [8:0] IDLE_SRC = 9'h001;

  irq_claim_controller #(
    .NUM_SRC     (9),
    .INVERT_MASK (9'h001),
    .ID_WIDTH    (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .irq_src     (irq_src),
    .enable_mask (enable_mask),
    .irq_out     (irq_out),
    .irq_ack     (irq_ack),
    .irq_id      (irq_id),
    .irq_done    (irq_done),
    .pending     (pending)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    irq_src     = IDLE_SRC;
    enable_mask = 9'h1FF;
    irq_ack     = 1'b0;
    irq_done    = 1'b0;
    reset_n     = 1'b0;
    cyc(2);
    reset_n     = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL rst_out: got %b want 0", irq_out); end
    n_chk++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL rst_id: got %0d want 0", irq_id); end
    n_chk++; if (pending !== 9'h000) begin n_fail++; $display("FAIL rst_pend: got %h want 000", pending); end
  endtask

  task automatic test_single();
    do_reset();
    irq_src = IDLE_SRC | 9'h004;
    cyc();
    irq_src = IDLE_SRC;
    n_chk++; if (pending !== 9'h004) begin n_fail++; $display("FAIL s3_pend: got %h want 004", pending); end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL s3_out_e0: got %b want 0", irq_out); end
    cyc();
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL s3_out_e1: got %b want 1", irq_out); end
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    n_chk++; if (irq_id !== 4'd3) begin n_fail++; $display("FAIL s3_id: got %0d want 3", irq_id); end
    n_chk++; if (pending !== 9'h000) begin n_fail++; $display("FAIL s3_clr: got %h want 000", pending); end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL s3_svc_out: got %b want 0", irq_out); end
    irq_done = 1'b1;
    cyc();
    irq_done = 1'b0;
    cyc(2);
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL s3_idle_out: got %b want 0", irq_out); end
    n_chk++; if (irq_id !== 4'd3) begin n_fail++; $display("FAIL s3_id_hold: got %0d want 3", irq_id); end
  endtask

  task automatic test_two_sources();
    do_reset();
    irq_src = IDLE_SRC | 9'h042;
    cyc();
    irq_src = IDLE_SRC;
    n_chk++; if (pending !== 9'h042) begin n_fail++; $display("FAIL p27_pend: got %h want 042", pending); end
    cyc();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    n_chk++; if (irq_id !== 4'd2) begin n_fail++; $display("FAIL p27_id1: got %0d want 2", irq_id); end
    n_chk++; if (pending !== 9'h040) begin n_fail++; $display("FAIL p27_pend1: got %h want 040", pending); end
    cyc();
    irq_done = 1'b1;
    cyc();
    irq_done = 1'b0;
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL p27_gap: got %b want 0", irq_out); end
    cyc();
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL p27_rereq: got %b want 1", irq_out); end
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    n_chk++; if (irq_id !== 4'd7) begin n_fail++; $display("FAIL p27_id2: got %0d want 7", irq_id); end
    n_chk++; if (pending !== 9'h000) begin n_fail++; $display("FAIL p27_pend2: got %h want 000", pending); end
  endtask

  task automatic test_invert();
    do_reset();
    cyc(2);
    n_chk++; if (pending !== 9'h000) begin n_fail++; $display("FAIL inv_noedge: got %h want 000", pending); end
    irq_src = 9'h000;
    cyc();
    n_chk++; if (pending !== 9'h001) begin n_fail++; $display("FAIL inv_pend: got %h want 001", pending); end
    cyc();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    n_chk++; if (irq_id !== 4'd1) begin n_fail++; $display("FAIL inv_id: got %0d want 1", irq_id); end
    irq_done = 1'b1;
    cyc();
    irq_done = 1'b0;
    cyc(4);
    n_chk++; if (pending !== 9'h000) begin n_fail++; $display("FAIL inv_level: got %h want 000", pending); end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL inv_level_out: got %b want 0", irq_out); end
    irq_src = IDLE_SRC;
    cyc(2);
    n_chk++; if (pending !== 9'h000) begin n_fail++; $display("FAIL inv_fall: got %h want 000", pending); end
  endtask

  task automatic test_enable();
    do_reset();
    enable_mask = 9'h1EF;
    irq_src = IDLE_SRC | 9'h010;
    cyc();
    irq_src = IDLE_SRC;
    cyc(3);
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL en_off_out: got %b want 0", irq_out); end
    n_chk++; if (pending !== 9'h010) begin n_fail++; $display("FAIL en_off_pend: got %h want 010", pending); end
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    n_chk++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL en_stray_ack: got %0d want 0", irq_id); end
    enable_mask = 9'h1FF;
    cyc();
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL en_on_out: got %b want 1", irq_out); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] first_id, second_id;
    logic [8:0] mid_pend;
`ifdef IRQ_ROUND_ROBIN_EN
    first_id = 4'd6; second_id = 4'd4; mid_pend = 9'h008;
`else
    first_id = 4'd4; second_id = 4'd6; mid_pend = 9'h020;
`endif
    do_reset();
    irq_src = IDLE_SRC | 9'h008;
    cyc();
    irq_src = IDLE_SRC;
    cyc();
    irq_src = IDLE_SRC | 9'h008;
    irq_ack = 1'b1;
    cyc();
    irq_src = IDLE_SRC;
    irq_ack = 1'b0;
    n_chk++; if (irq_id !== 4'd4) begin n_fail++; $display("FAIL b2b_id0: got %0d want 4", irq_id); end
    n_chk++; if (pending !== 9'h008) begin n_fail++; $display("FAIL b2b_setwins: got %h want 008", pending); end
    irq_src = IDLE_SRC | 9'h020;
    cyc();
    irq_src = IDLE_SRC;
    n_chk++; if (pending !== 9'h028) begin n_fail++; $display("FAIL b2b_svc_pend: got %h want 028", pending); end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL b2b_svc_out: got %b want 0", irq_out); end
    irq_done = 1'b1;
    cyc();
    irq_done = 1'b0;
    cyc();
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL b2b_rereq: got %b want 1", irq_out); end
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    n_chk++; if (irq_id !== first_id) begin n_fail++; $display("FAIL b2b_id1: got %0d want %0d", irq_id, first_id); end
    n_chk++; if (pending !== mid_pend) begin n_fail++; $display("FAIL b2b_pend1: got %h want %h", pending, mid_pend); end
    irq_done = 1'b1;
    cyc();
    irq_done = 1'b0;
    cyc();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    n_chk++; if (irq_id !== second_id) begin n_fail++; $display("FAIL b2b_id2: got %0d want %0d", irq_id, second_id); end
    n_chk++; if (pending !== 9'h000) begin n_fail++; $display("FAIL b2b_pend2: got %h want 000", pending); end
  endtask

  task automatic test_reset_mid_service();
    do_reset();
    irq_src = IDLE_SRC | 9'h002;
    cyc();
    irq_src = IDLE_SRC;
    cyc();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    irq_src = IDLE_SRC | 9'h080;
    cyc();
    irq_src = IDLE_SRC;
    n_chk++; if (irq_id !== 4'd2) begin n_fail++; $display("FAIL rms_id: got %0d want 2", irq_id); end
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL rms_out: got %b want 0", irq_out); end
    n_chk++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL rms_id0: got %0d want 0", irq_id); end
    n_chk++; if (pending !== 9'h000) begin n_fail++; $display("FAIL rms_pend: got %h want 000", pending); end
    irq_done = 1'b1;
    cyc();
    irq_done = 1'b0;
    cyc(2);
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL rms_done_out: got %b want 0", irq_out); end
    n_chk++; if (pending !== 9'h000) begin n_fail++; $display("FAIL rms_done_pend: got %h want 000", pending); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_sources();
    test_invert();
    test_enable();
    test_back_to_back();
    test_reset_mid_service();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_claim_controller.md
# irq_claim_controller

Sequential counterpart to the 9-input bubbled OR reduction used for interrupt request merging. It latches up to nine per-source interrupt edges, applies a per-source inversion mask for active-low sources, presents one merged request to the CPU, and answers the CPU's acknowledge with the encoded source ID. It then holds that claim until the CPU signals end of service. It sits between the peripheral request lines (VGA vsync, timer, keyboard, …) and the RISC-V core's interrupt/ERET logic.

## Interface
- `NUM_SRC`, 9: number of request sources. Fixed at 9 for this project; the RTL is written generically for 1..15.
- `INVERT_MASK`, 9'h000: bit i=1 means source i+1 is active-low and is inverted before edge detection.
- `ID_WIDTH`, 4: width of the encoded ID. ID 0 means "none"; IDs 1..NUM_SRC identify sources.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `irq_src`  in  NUM_SRC  raw request lines, synchronous to `clock`. Bit 0 is source 1.
- `enable_mask`  in  NUM_SRC  per-source enable; a disabled source still latches pending but is never claimed.
- `irq_out`  out  1  merged request to the core.
- `irq_ack`  in  1  core claims the current request (one-cycle pulse).
- `irq_id`  out  ID_WIDTH  ID of the claimed source, valid while in SERVICE.
- `irq_done`  in  1  core finished servicing (ERET); one-cycle pulse.
- `pending`  out  NUM_SRC  latched pending bits, for CSR readback.

## Operation
- Real input: `real[i] = irq_src[i] ^ INVERT_MASK[i]`. The `prev` register holds `real` from the previous cycle.
- Edge: `real[i] & ~prev[i]` sets `pending[i]`. Level-held sources do not re-fire.
- FSM states:
  - IDLE → REQ when `|(pending & enable_mask)`.
  - REQ → IDLE if `(pending & enable_mask)` becomes 0.
  - REQ → SERVICE on `irq_ack`. The winner's ID is latched into `irq_id` and the winner's pending bit is cleared.
  - SERVICE → IDLE on `irq_done`.
- Winner: the lowest-index enabled pending bit (fixed priority; see Configuration).
- `irq_out` = (state == REQ). It is deasserted in SERVICE, so there is no nesting.
- `irq_ack` outside REQ is ignored. `irq_done` outside SERVICE is ignored.
- Same-cycle new edge and claim-clear on the same bit: the set wins, so the bit stays pending and re-requests after `irq_done`.
- Edges arriving during SERVICE are latched and are served after returning to IDLE.
- Reset values: state=IDLE, `pending`=0, `prev`=all ones (lines asserted through reset do not fire), `irq_out`=0, `irq_id`=0.
- Reset mid-service: abandons the claim with no residue; all outputs return to their reset values the cycle after the edge with `reset_n`=0.

## Timing
- Source asserted and first sampled at edge E0 → `pending[i]`=1 after E0 → `irq_out`=1 after E1. Latency is 2 cycles.
- `irq_ack` sampled high at edge Ea:
  - after Ea: `irq_id` valid, `irq_out`=0, pending bit cleared.
- `irq_done` sampled at Ed → IDLE after Ed. If further pending exists, `irq_out`=1 after Ed+1, so the minimum gap between requests is 1 cycle.
- `irq_id` holds its value through IDLE and REQ until the next claim; it is not cleared on `irq_done`.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- `IRQ_ROUND_ROBIN_EN`
  - Defined: rotating priority. A `last_id` register (reset 0) makes the search start at source `last_id+1` and wrap from NUM_SRC back to 1. `last_id` updates on each claim.
  - Undefined: fixed priority with source 1 highest, and no `last_id` register.

## Structure
- Shared package `irq_pkg`:
  - FSM state enum (`IRQ_IDLE`, `IRQ_REQ`, `IRQ_SERVICE`)
  - `IRQ_ID_NONE` = 0
  - default `NUM_SRC`/`ID_WIDTH` constants
- One sub-module, `irq_prio_encoder`: combinational masked priority encoder taking `pending & enable_mask` and a start index (tied to 0 when round-robin is off), returning the winner ID and a valid flag.

## Test plan
- Source 3 pulses high for one cycle, `enable_mask`=9'h1FF → `irq_out` high 2 cycles later; ack → `irq_id`=3, `pending`=0, `irq_out`=0; done → stays IDLE.
- Sources 2 and 7 rise together → first claim `irq_id`=2; after done, `irq_out` returns 1 cycle later; second claim `irq_id`=7.
- `INVERT_MASK`=9'h001, source 1 held high through reset then driven low → exactly one pending set, claim `irq_id`=1. A level held asserted does not re-fire.
- Source 5 pending with `enable_mask[4]`=0 → `irq_out` stays 0 and `pending`=9'h010. Setting the enable → `irq_out`=1 one cycle later.
- During SERVICE of source 4: source 4 edge coincident with the ack cycle, plus a source 6 edge → after done, fixed priority claims 4 and then 6. With `IRQ_ROUND_ROBIN_EN`, 6 is claimed before 4.
- `reset_n`=0 for one cycle in SERVICE → next cycle `irq_out`=0, `irq_id`=0, `pending`=0. A stray `irq_done` afterwards has no effect.
